// File: rtl/ddr_burst_reader_pkg.sv
// Shared DDR word geometry and the burst FSM state encoding used by the
// burst reader and its sub-blocks.
package ddr_pkg;

  localparam int DdrWordWidth = 64;
  localparam int DdrWordBytes = 8;
  localparam int DdrAlignBits = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } burst_state_e;

endpackage

// File: rtl/ddr_burst_reader_sync_fifo.sv
// First-word fall-through synchronous FIFO; data_o shows the head entry
// whenever empty_o is low.
module sync_fifo #(
  parameter int Width = 64,
  parameter int Depth = 32,
  localparam int PtrW = $clog2(Depth),
  localparam int CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !full_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));

endmodule

// File: rtl/ddr_burst_reader.sv
// Burst read engine: issues one 64-bit read per cycle, buffers the returns
// and streams them out, with credits so no return is ever dropped.
module ddr_burst_reader
  import ddr_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 16,
  parameter int FifoDepth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [AddrWidth-1:0]    base_addr_i,
  input  logic [LenWidth-1:0]     len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [AddrWidth-1:0]    mem_addr_o,
  output logic                    mem_read_en_o,
  input  logic [DdrWordWidth-1:0] mem_data_i,
  input  logic                    mem_data_valid_i,
  output logic [DdrWordWidth-1:0] data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o
);

  localparam int CntW = $clog2(FifoDepth) + 1;

  burst_state_e         state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] mem_addr_q;
  logic [LenWidth-1:0]  remaining_q, remaining_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [LenWidth-1:0]  delivered_q;
  logic [CntW-1:0]      outstanding_q;
  logic [CntW-1:0]      fifo_count;
  logic [CntW:0]        in_flight;
  logic                 mem_read_en_q, error_q, error_d;
  logic                 issue, accept, push, pop, credit_ok;
  logic                 fifo_empty, fifo_full;

  // Returns already buffered plus reads still in the memory pipe must fit.
  assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit_ok = in_flight < (CntW + 1)'(FifoDepth);
  assign push      = mem_data_valid_i && (outstanding_q != '0);
  assign valid_o   = !fifo_empty;
  assign pop       = valid_o && ready_i;
  assign last_o    = valid_o && (delivered_q == len_q - 1'b1);

  assign busy_o        = (state_q == ISSUE) || (state_q == DRAIN);
  assign done_o        = (state_q == DONE);
  assign error_o       = error_q;
  assign mem_read_en_o = mem_read_en_q;
  assign mem_addr_o    = mem_addr_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    error_d     = 1'b0;
    issue       = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (base_addr_i[DdrAlignBits-1:0] != '0) begin
            error_d = 1'b1;
          end else if (len_i == '0) begin
            state_d = DONE;
          end else begin
            accept      = 1'b1;
            addr_d      = base_addr_i;
            remaining_d = len_i;
            len_d       = len_i;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if ((remaining_q != '0) && credit_ok) begin
          issue       = 1'b1;
          addr_d      = addr_q + AddrWidth'(DdrWordBytes);
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LenWidth'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_o) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      len_q         <= '0;
      delivered_q   <= '0;
      outstanding_q <= '0;
      mem_addr_q    <= '0;
      mem_read_en_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      len_q         <= len_d;
      error_q       <= error_d;
      mem_read_en_q <= issue;
      if (issue) mem_addr_q <= addr_q;
      if (accept) delivered_q <= '0;
      else if (pop) delivered_q <= delivered_q + 1'b1;
      case ({issue, push})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  sync_fifo #(
    .Width(DdrWordWidth),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .data_i (mem_data_i),
    .pop_i  (pop),
    .data_o (data_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_ddr_burst_reader.sv
// Directed bench for ddr_burst_reader with a 16-cycle, never-reset memory
// pipeline model whose read data is {~addr, addr}.
module tb_ddr_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len_in;
  logic        busy_o, done_o, error_o, mem_read_en_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_data;
  logic        mem_data_valid;
  logic [63:0] data_o;
  logic        valid_o, last_o;
  logic        ready;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  ddr_burst_reader dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .base_addr_i     (base_addr),
    .len_i           (len_in),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .mem_addr_o      (mem_addr_o),
    .mem_read_en_o   (mem_read_en_o),
    .mem_data_i      (mem_data),
    .mem_data_valid_i(mem_data_valid),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .ready_i         (ready),
    .last_o          (last_o)
  );

  function automatic logic [63:0] memWord(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Memory pipeline: deliberately never reset, so stale returns survive a reset.
  logic [15:0] pipeV = '0;
  logic [31:0] pipeA [16];
  always @(posedge clk) begin
    pipeV <= {pipeV[14:0], mem_read_en_o};
    pipeA[0] <= mem_addr_o;
    for (int i = 1; i < 16; i++) pipeA[i] <= pipeA[i-1];
  end
  assign mem_data_valid = pipeV[15];
  assign mem_data       = memWord(pipeA[15]);

  // Monitor logs; only this block writes them, tests read via snapshots.
  logic [31:0] readAddr [$];
  int          readCyc  [$];
  logic [63:0] outData  [$];
  logic        outLast  [$];
  int cycle = 0, errorCount = 0, doneCount = 0, busyCount = 0, validCount = 0;
  int doneCycle = 0, lastHsCycle = 0, inFlight = 0, maxInFlight = 0;

  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      inFlight = 0;
    end else begin
      if (mem_read_en_o) begin
        readAddr.push_back(mem_addr_o);
        readCyc.push_back(cycle);
        inFlight++;
      end
      if (valid_o && ready) begin
        outData.push_back(data_o);
        outLast.push_back(last_o);
        inFlight--;
        if (last_o) lastHsCycle = cycle;
      end
      if (done_o) begin
        doneCount++;
        doneCycle = cycle;
      end
      if (error_o) errorCount++;
      if (busy_o) busyCount++;
      if (valid_o) validCount++;
      if (inFlight > maxInFlight) maxInFlight = inFlight;
    end
  end

  task automatic do_start(input logic [31:0] base, input logic [15:0] len);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; len_in = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = doneCount;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (doneCount > d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len_in = '0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nCompared++;
    if ({busy_o, done_o, error_o, mem_read_en_o, valid_o, last_o} !== 6'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {busy_o, done_o, error_o, mem_read_en_o, valid_o, last_o});
    end
    nCompared++;
    if (mem_addr_o !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    int r0 = readAddr.size();
    int o0 = outData.size();
    int e0 = errorCount;
    bit ok;
    ready = 1'b1;
    do_start(32'h100, 16'd4);
    wait_done(200, ok);
    nCompared++;
    if (!ok) begin nMismatched++; $display("[TB] FAIL basic_done_timeout: got no done expected done"); end
    nCompared++;
    if (readAddr.size() - r0 !== 4) begin
      nMismatched++;
      $display("[TB] FAIL basic_nreads: got %0d expected 4", readAddr.size() - r0);
    end
    for (int i = 0; i < 4 && r0 + i < readAddr.size(); i++) begin
      nCompared++;
      if (readAddr[r0+i] !== 32'h100 + 32'(8*i) || readCyc[r0+i] !== readCyc[r0] + i) begin
        nMismatched++;
        $display("[TB] FAIL basic_read%0d: got addr %h cyc %0d expected addr %h cyc %0d",
                 i, readAddr[r0+i], readCyc[r0+i], 32'h100 + 32'(8*i), readCyc[r0] + i);
      end
    end
    nCompared++;
    if (outData.size() - o0 !== 4) begin
      nMismatched++;
      $display("[TB] FAIL basic_nwords: got %0d expected 4", outData.size() - o0);
    end
    for (int i = 0; i < 4 && o0 + i < outData.size(); i++) begin
      nCompared++;
      if (outData[o0+i] !== memWord(32'h100 + 32'(8*i)) || outLast[o0+i] !== (i == 3)) begin
        nMismatched++;
        $display("[TB] FAIL basic_word%0d: got %h last %b expected %h last %b",
                 i, outData[o0+i], outLast[o0+i], memWord(32'h100 + 32'(8*i)), (i == 3));
      end
    end
    nCompared++;
    if (doneCycle !== lastHsCycle + 1) begin
      nMismatched++;
      $display("[TB] FAIL basic_done_timing: got cycle %0d expected %0d", doneCycle, lastHsCycle + 1);
    end
    #1;
    nCompared++;
    if (busy_o !== 1'b0 || errorCount !== e0) begin
      nMismatched++;
      $display("[TB] FAIL basic_idle: got busy %b errors %0d expected busy 0 errors %0d",
               busy_o, errorCount, e0);
    end
  endtask

  task automatic test_backpressure;
    int r0 = readAddr.size();
    int o0 = outData.size();
    int nLast = 0;
    bit ok;
    ready = 1'b0;
    do_start(32'h2000, 16'd100);
    repeat (200) @(posedge clk);
    nCompared++;
    if (readAddr.size() - r0 !== 32 || outData.size() - o0 !== 0) begin
      nMismatched++;
      $display("[TB] FAIL bp_stalled: got reads %0d words %0d expected reads 32 words 0",
               readAddr.size() - r0, outData.size() - o0);
    end
    #1; ready = 1'b1;
    wait_done(1000, ok);
    nCompared++;
    if (!ok) begin nMismatched++; $display("[TB] FAIL bp_done_timeout: got no done expected done"); end
    nCompared++;
    if (outData.size() - o0 !== 100) begin
      nMismatched++;
      $display("[TB] FAIL bp_nwords: got %0d expected 100", outData.size() - o0);
    end
    for (int i = 0; i < 100 && o0 + i < outData.size(); i++) begin
      if (outLast[o0+i]) nLast++;
      nCompared++;
      if (outData[o0+i] !== memWord(32'h2000 + 32'(8*i))) begin
        nMismatched++;
        $display("[TB] FAIL bp_word%0d: got %h expected %h", i, outData[o0+i], memWord(32'h2000 + 32'(8*i)));
      end
    end
    nCompared++;
    if (nLast !== 1 || outLast[outLast.size()-1] !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL bp_last: got %0d lasts expected 1 on final word", nLast);
    end
    nCompared++;
    if (maxInFlight > 32) begin
      nMismatched++;
      $display("[TB] FAIL bp_credit: got max in flight %0d expected <= 32", maxInFlight);
    end
  endtask

  task automatic test_rejects;
    int r0 = readAddr.size();
    int e0 = errorCount;
    int d0 = doneCount;
    int b0 = busyCount;
    int v0;
    do_start(32'h104, 16'd8);
    repeat (30) @(posedge clk);
    nCompared++;
    if (errorCount - e0 !== 1 || readAddr.size() - r0 !== 0 || busyCount - b0 !== 0 || doneCount - d0 !== 0) begin
      nMismatched++;
      $display("[TB] FAIL reject_misaligned: got err %0d reads %0d busy %0d done %0d expected 1 0 0 0",
               errorCount - e0, readAddr.size() - r0, busyCount - b0, doneCount - d0);
    end
    e0 = errorCount; d0 = doneCount; v0 = validCount; r0 = readAddr.size();
    do_start(32'h200, 16'd0);
    repeat (30) @(posedge clk);
    nCompared++;
    if (doneCount - d0 !== 1 || readAddr.size() - r0 !== 0 || validCount - v0 !== 0 || errorCount - e0 !== 0) begin
      nMismatched++;
      $display("[TB] FAIL reject_zero_len: got done %0d reads %0d valid %0d err %0d expected 1 0 0 0",
               doneCount - d0, readAddr.size() - r0, validCount - v0, errorCount - e0);
    end
  endtask

  task automatic test_start_while_busy;
    int r0 = readAddr.size();
    int d0 = doneCount;
    bit ok;
    ready = 1'b1;
    do_start(32'h400, 16'd8);
    repeat (2) @(posedge clk);
    do_start(32'h800, 16'd8);
    wait_done(200, ok);
    repeat (40) @(posedge clk);
    nCompared++;
    if (!ok || readAddr.size() - r0 !== 8 || doneCount - d0 !== 1) begin
      nMismatched++;
      $display("[TB] FAIL busy_ignore: got done_ok %b reads %0d dones %0d expected 1 8 1",
               ok, readAddr.size() - r0, doneCount - d0);
    end
    for (int i = 0; i < 8 && r0 + i < readAddr.size(); i++) begin
      nCompared++;
      if (readAddr[r0+i] !== 32'h400 + 32'(8*i)) begin
        nMismatched++;
        $display("[TB] FAIL busy_read%0d: got %h expected %h", i, readAddr[r0+i], 32'h400 + 32'(8*i));
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    int o0 = outData.size();
    int r0, v0, d0;
    bit ok;
    ready = 1'b1;
    do_start(32'h1000, 16'd16);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (outData.size() - o0 >= 5) begin ok = 1'b1; break; end
    end
    nCompared++;
    if (!ok) begin nMismatched++; $display("[TB] FAIL rst_mid_timeout: got fewer than 5 words expected 5"); end
    @(negedge clk); rst_n = 1'b0;
    #1;
    nCompared++;
    if ({busy_o, done_o, error_o, mem_read_en_o, valid_o, last_o} !== 6'b0 || mem_addr_o !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL rst_mid_outputs: got %b addr %h expected 000000 addr 0",
               {busy_o, done_o, error_o, mem_read_en_o, valid_o, last_o}, mem_addr_o);
    end
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    r0 = readAddr.size(); v0 = validCount; d0 = doneCount;
    repeat (30) @(posedge clk);
    nCompared++;
    if (validCount - v0 !== 0 || readAddr.size() - r0 !== 0 || doneCount - d0 !== 0) begin
      nMismatched++;
      $display("[TB] FAIL rst_mid_stale: got valid %0d reads %0d done %0d expected 0 0 0",
               validCount - v0, readAddr.size() - r0, doneCount - d0);
    end
    o0 = outData.size();
    do_start(32'h0, 16'd2);
    wait_done(200, ok);
    repeat (5) @(posedge clk);
    nCompared++;
    if (!ok || outData.size() - o0 !== 2) begin
      nMismatched++;
      $display("[TB] FAIL rst_mid_restart: got done_ok %b words %0d expected 1 2", ok, outData.size() - o0);
    end
    for (int i = 0; i < 2 && o0 + i < outData.size(); i++) begin
      nCompared++;
      if (outData[o0+i] !== memWord(32'(8*i))) begin
        nMismatched++;
        $display("[TB] FAIL rst_mid_word%0d: got %h expected %h", i, outData[o0+i], memWord(32'(8*i)));
      end
    end
  endtask

  task automatic test_wrap;
    int r0 = readAddr.size();
    int o0 = outData.size();
    int e0 = errorCount;
    bit ok;
    ready = 1'b1;
    do_start(32'hFFFF_FFF8, 16'd2);
    wait_done(200, ok);
    nCompared++;
    if (!ok || readAddr.size() - r0 !== 2 || errorCount !== e0) begin
      nMismatched++;
      $display("[TB] FAIL wrap_basic: got done_ok %b reads %0d errs %0d expected 1 2 0",
               ok, readAddr.size() - r0, errorCount - e0);
    end
    if (readAddr.size() - r0 >= 2) begin
      nCompared++;
      if (readAddr[r0] !== 32'hFFFF_FFF8 || readAddr[r0+1] !== 32'h0) begin
        nMismatched++;
        $display("[TB] FAIL wrap_addr: got %h %h expected fffffff8 00000000", readAddr[r0], readAddr[r0+1]);
      end
    end
    if (outData.size() - o0 >= 2) begin
      nCompared++;
      if (outData[o0] !== memWord(32'hFFFF_FFF8) || outData[o0+1] !== memWord(32'h0)) begin
        nMismatched++;
        $display("[TB] FAIL wrap_data: got %h %h expected %h %h",
                 outData[o0], outData[o0+1], memWord(32'hFFFF_FFF8), memWord(32'h0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_rejects();
    test_start_while_busy();
    test_reset_mid_burst();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ddr_burst_reader.md
Name: ddr_burst_reader

Overview:
- Burst read engine upstream of the 64-bit DDR model/controller.
- Accepts a command (byte base address, length in 64-bit words) and issues one word read per cycle on the memory read port.
- Collects the fixed-latency read returns into an internal FIFO and presents them as a valid/ready stream with a last marker.
- Uses credit-based flow control so that no return is ever dropped under output backpressure.

Parameters:
- AddrWidth, 32, byte address width; must match the memory port.
- LenWidth, 16, width of the burst length in words.
- FifoDepth, 32, return buffer depth in words; power of two, at least 2.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  command strobe; sampled only in IDLE.
- base_addr_i  input  AddrWidth  byte start address; must be 8-byte aligned.
- len_i  input  LenWidth  burst length in 64-bit words.
- busy_o  output  1  high from command accept until the done pulse.
- done_o  output  1  one-cycle pulse at burst completion.
- error_o  output  1  one-cycle pulse when a command is rejected.
- mem_addr_o  output  AddrWidth  read byte address to memory.
- mem_read_en_o  output  1  read strobe, one word per high cycle.
- mem_data_i  input  64  read return data.
- mem_data_valid_i  input  1  read return valid; returns arrive in order.
- data_o  output  64  stream data.
- valid_o  output  1  stream valid.
- ready_i  input  1  stream ready.
- last_o  output  1  high with the final word of the burst.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; all counters and the FIFO are cleared.
  - busy_o, done_o, error_o, mem_read_en_o, valid_o and last_o are 0; mem_addr_o is 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, with start_i=1:
  - base_addr_i[2:0]!=0: error_o pulses next cycle; stay IDLE; no reads.
  - len_i==0: go to DONE; no reads.
  - Otherwise: latch addr and remaining=len_i, set busy_o=1, go to ISSUE.
- IDLE, with start_i=0: remain IDLE.
- start_i outside IDLE is ignored.
- ISSUE:
  - Issue a read when remaining>0 and credit>0, where credit = FifoDepth - (fifo_count + outstanding).
  - mem_read_en_o and mem_addr_o are registered outputs.
  - On each issue: addr += 8, remaining -= 1, outstanding += 1.
  - Go to DRAIN after the last issue.
- Counters:
  - outstanding += 1 on issue and -= 1 on mem_data_valid_i; both in the same cycle gives no net change.
  - Width is clog2(FifoDepth)+1.
- Returns:
  - mem_data_valid_i pushes mem_data_i into the FIFO.
  - A return with outstanding==0 is discarded. This drops stale returns after reset mid-burst, because the memory pipeline is not reset.
- Credit ensures a push never finds the FIFO full; an overflow is an assertion failure.
- Address arithmetic wraps modulo 2^AddrWidth with no error.
- Stream output:
  - valid_o = FIFO not empty; data_o = FIFO head (first-word fall-through).
  - Pop on valid_o && ready_i.
  - Simultaneous push and pop leaves the count unchanged.
- last_o:
  - A delivered-word counter tracks stream handshakes.
  - last_o = valid_o && (delivered == len-1).
- DRAIN: wait until the handshake with last_o=1, then go to DONE.
- DONE: done_o=1 for one cycle, busy_o=0 in the same cycle, then IDLE.
  - Earliest new start is the cycle after done_o.
- Latency:
  - First mem_read_en_o one cycle after start accept.
  - Throughput is one word per cycle when ready_i is held high and FifoDepth exceeds the memory round trip.
- Reset asserted mid-burst aborts immediately with all outputs at reset values; no done_o.

Decomposition:
- Package ddr_pkg:
  - DdrWordWidth=64, DdrWordBytes=8, DdrAlignBits=3.
  - typedef enum burst_state_e {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module sync_fifo:
  - Parameters Width, Depth.
  - First-word fall-through; async active-low reset.
  - Ports push, pop, full, empty, count.

Test Plan:
- Basic burst: base=0x100, len=4, ready_i=1, memory latency 16 → reads at 0x100, 0x108, 0x110, 0x118 on consecutive cycles; 4 words out in order; last_o on the 4th; done_o one cycle after the 4th handshake.
- Backpressure: len=100, FifoDepth=32, ready_i=0 for 200 cycles, then 1 → at most 32 reads issued before release; outstanding+count never exceeds 32; all 100 words delivered in order with no loss.
- Rejects: base=0x104, len=8 → error_o pulse, zero mem_read_en_o, busy_o stays 0. Base=0x200, len=0 → done_o pulse, no reads, no valid_o.
- Start while busy: second start_i (base=0x800) during an active burst of len=8 → ignored; only the original 8 addresses appear.
- Reset mid-burst: rst_ni low at word 5 of len=16, then release and start base=0x0, len=2 → outputs zero during reset; stale returns discarded; exactly 2 words from 0x0 and 0x8 delivered.
- Wrap: base=0xFFFF_FFF8, len=2 → addresses 0xFFFF_FFF8 then 0x0000_0000; no error.
